// File: rtl/clause_data_pkg.sv
// rtl/clause_data_pkg.sv - literal encodings and state-word field offsets for clause_data
package clause_data_pkg;

    localparam logic [1:0] LIT_NONE = 2'b00;
    localparam logic [1:0] LIT_NEG  = 2'b01;
    localparam logic [1:0] LIT_POS  = 2'b10;
    localparam logic [1:0] LIT_BAD  = 2'b11;

    localparam int VS_LEVEL_LSB      = 0;
    localparam int VS_VALUE_BITS     = 2;
    localparam int VS_VALUE_OUT_BITS = 3;

    localparam int LS_HAS_BKT_BIT = 0;
    localparam int LS_DCD_BIN_LSB = 1;

    // Var-state fields sit above the level field, so their offsets follow WIDTH_LVL.
    function automatic int vs_implied_bit(input int width_lvl);
        return width_lvl;
    endfunction

    function automatic int vs_value_lsb(input int width_lvl);
        return width_lvl + 1;
    endfunction

endpackage

// File: rtl/slot_capture_reg.sv
// rtl/slot_capture_reg.sv - per-slot strobe-enabled register array with capture pulse
module slot_capture_reg #(
    parameter int NUM_SLOTS = 8,
    parameter int WIDTH     = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SLOTS-1:0]       wr,
    input  logic [NUM_SLOTS*WIDTH-1:0] data,
    output logic [NUM_SLOTS*WIDTH-1:0] q,
    output logic                       upd
);

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q[k*WIDTH +: WIDTH] <= '0;
            end else if (wr[k]) begin
                q[k*WIDTH +: WIDTH] <= data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd <= 1'b0;
        end else begin
            upd <= |wr;
        end
    end

endmodule

// File: rtl/clause_data.sv
// rtl/clause_data.sv - passive capture and decode of clause, var-state and lvl-state load buses
module clause_data
    import clause_data_pkg::*;
#(
    parameter int NUM_CLAUSES_A_BIN = 8,
    parameter int NUM_VARS_A_BIN    = 8,
    parameter int NUM_LVLS_A_BIN    = 8,
    parameter int WIDTH_LVL         = 16,
    parameter int WIDTH_BIN_ID      = 10,
    parameter int WIDTH_VAR_STATES  = 19,
    parameter int WIDTH_LVL_STATES  = 11
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_CLAUSES_A_BIN-1:0]               wr_carray_i,
    input  logic [2*NUM_VARS_A_BIN-1:0]                clause_i,
    input  logic [NUM_VARS_A_BIN-1:0]                  wr_var_states_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] var_states_i,
    input  logic [NUM_LVLS_A_BIN-1:0]                  wr_lvl_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_i,
    output logic [NUM_CLAUSES_A_BIN-1:0]               clause_slot_o,
    output logic [NUM_VARS_A_BIN-1:0]                  lit_pos_o,
    output logic [NUM_VARS_A_BIN-1:0]                  lit_neg_o,
    output logic [3:0]                                 lit_cnt_o,
    output logic                                       lit_err_o,
    output logic                                       clause_upd_o,
    output logic [3*NUM_VARS_A_BIN-1:0]                vs_value_o,
    output logic [NUM_VARS_A_BIN-1:0]                  vs_implied_o,
    output logic [WIDTH_LVL*NUM_VARS_A_BIN-1:0]        vs_level_o,
    output logic                                       vs_upd_o,
    output logic [WIDTH_BIN_ID*NUM_LVLS_A_BIN-1:0]     ls_dcd_bin_o,
    output logic [NUM_LVLS_A_BIN-1:0]                  ls_has_bkt_o,
    output logic                                       ls_upd_o
);

    localparam int VS_IMPLIED = vs_implied_bit(WIDTH_LVL);
    localparam int VS_VAL_LSB = vs_value_lsb(WIDTH_LVL);

    logic [2*NUM_VARS_A_BIN-1:0]                clause_q;
    logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vs_q;
    logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] ls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clause_q      <= '0;
            clause_slot_o <= '0;
            clause_upd_o  <= 1'b0;
        end else begin
            clause_upd_o <= |wr_carray_i;
            if (|wr_carray_i) begin
                clause_q      <= clause_i;
                clause_slot_o <= wr_carray_i;
            end
        end
    end

    // An invalid pair flags the clause but contributes to neither mask nor count.
    always_comb begin
        lit_pos_o = '0;
        lit_neg_o = '0;
        lit_err_o = 1'b0;
        lit_cnt_o = 4'd0;
        for (int k = 0; k < NUM_VARS_A_BIN; k++) begin
            case (clause_q[2*k +: 2])
                LIT_POS: begin
                    lit_pos_o[k] = 1'b1;
                    lit_cnt_o    = lit_cnt_o + 4'd1;
                end
                LIT_NEG: begin
                    lit_neg_o[k] = 1'b1;
                    lit_cnt_o    = lit_cnt_o + 4'd1;
                end
                LIT_BAD: lit_err_o = 1'b1;
                default: ;
            endcase
        end
    end

    slot_capture_reg #(
        .NUM_SLOTS (NUM_VARS_A_BIN),
        .WIDTH     (WIDTH_VAR_STATES)
    ) u_vs_reg (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr_var_states_i),
        .data (var_states_i),
        .q    (vs_q),
        .upd  (vs_upd_o)
    );

    slot_capture_reg #(
        .NUM_SLOTS (NUM_LVLS_A_BIN),
        .WIDTH     (WIDTH_LVL_STATES)
    ) u_ls_reg (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr_lvl_states_i),
        .data (lvl_states_i),
        .q    (ls_q),
        .upd  (ls_upd_o)
    );

    for (genvar k = 0; k < NUM_VARS_A_BIN; k++) begin : g_vs
        localparam int B = k * WIDTH_VAR_STATES;
        assign vs_value_o[VS_VALUE_OUT_BITS*k +: VS_VALUE_OUT_BITS] =
            {1'b0, vs_q[B + VS_VAL_LSB +: VS_VALUE_BITS]};
        assign vs_implied_o[k] = vs_q[B + VS_IMPLIED];
        assign vs_level_o[WIDTH_LVL*k +: WIDTH_LVL] = vs_q[B + VS_LEVEL_LSB +: WIDTH_LVL];
    end

    for (genvar k = 0; k < NUM_LVLS_A_BIN; k++) begin : g_ls
        localparam int B = k * WIDTH_LVL_STATES;
        assign ls_has_bkt_o[k] = ls_q[B + LS_HAS_BKT_BIT];
        assign ls_dcd_bin_o[WIDTH_BIN_ID*k +: WIDTH_BIN_ID] = ls_q[B + LS_DCD_BIN_LSB +: WIDTH_BIN_ID];
    end

endmodule

// File: tb/tb_clause_data.sv
// tb/tb_clause_data.sv - self-checking bench for clause_data against a behavioural model
module tb_clause_data;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int WL = 16;
    localparam int WB = 10;
    localparam int VW = 19;
    localparam int LW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   wr_carray_i;
    logic [2*NV-1:0] clause_i;
    logic [NV-1:0]   wr_var_states_i;
    logic [VW*NV-1:0] var_states_i;
    logic [NL-1:0]   wr_lvl_states_i;
    logic [LW*NL-1:0] lvl_states_i;
    logic [NC-1:0]   clause_slot_o;
    logic [NV-1:0]   lit_pos_o, lit_neg_o;
    logic [3:0]      lit_cnt_o;
    logic            lit_err_o, clause_upd_o;
    logic [3*NV-1:0] vs_value_o;
    logic [NV-1:0]   vs_implied_o;
    logic [WL*NV-1:0] vs_level_o;
    logic            vs_upd_o;
    logic [WB*NL-1:0] ls_dcd_bin_o;
    logic [NL-1:0]   ls_has_bkt_o;
    logic            ls_upd_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*NV-1:0] m_clause;
    logic [NC-1:0]   m_slot;
    logic [VW-1:0]   m_vs [NV];
    logic [LW-1:0]   m_ls [NL];
    logic            m_cupd, m_vupd, m_lupd;

    always #5 clk = ~clk;

    clause_data dut (
        .clk             (clk),
        .rst             (rst),
        .wr_carray_i     (wr_carray_i),
        .clause_i        (clause_i),
        .wr_var_states_i (wr_var_states_i),
        .var_states_i    (var_states_i),
        .wr_lvl_states_i (wr_lvl_states_i),
        .lvl_states_i    (lvl_states_i),
        .clause_slot_o   (clause_slot_o),
        .lit_pos_o       (lit_pos_o),
        .lit_neg_o       (lit_neg_o),
        .lit_cnt_o       (lit_cnt_o),
        .lit_err_o       (lit_err_o),
        .clause_upd_o    (clause_upd_o),
        .vs_value_o      (vs_value_o),
        .vs_implied_o    (vs_implied_o),
        .vs_level_o      (vs_level_o),
        .vs_upd_o        (vs_upd_o),
        .ls_dcd_bin_o    (ls_dcd_bin_o),
        .ls_has_bkt_o    (ls_has_bkt_o),
        .ls_upd_o        (ls_upd_o)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_clause = '0;
        m_slot   = '0;
        m_cupd   = 1'b0;
        m_vupd   = 1'b0;
        m_lupd   = 1'b0;
        for (int k = 0; k < NV; k++) m_vs[k] = '0;
        for (int k = 0; k < NL; k++) m_ls[k] = '0;
    endtask

    task automatic model_capture;
        m_cupd = (wr_carray_i != 0);
        m_vupd = (wr_var_states_i != 0);
        m_lupd = (wr_lvl_states_i != 0);
        if (m_cupd) begin
            m_clause = clause_i;
            m_slot   = wr_carray_i;
        end
        for (int k = 0; k < NV; k++)
            if (wr_var_states_i[k]) m_vs[k] = var_states_i[k*VW +: VW];
        for (int k = 0; k < NL; k++)
            if (wr_lvl_states_i[k]) m_ls[k] = lvl_states_i[k*LW +: LW];
    endtask

    task automatic idle_inputs;
        wr_carray_i     = '0;
        wr_var_states_i = '0;
        wr_lvl_states_i = '0;
    endtask

    function automatic logic [NV-1:0] exp_mask(input logic [2*NV-1:0] c, input logic [1:0] code);
        logic [NV-1:0] m;
        m = '0;
        for (int k = 0; k < NV; k++) m[k] = (c[2*k +: 2] == code);
        return m;
    endfunction

    function automatic logic [3*NV-1:0] exp_vs_value();
        logic [3*NV-1:0] v;
        for (int k = 0; k < NV; k++) v[3*k +: 3] = {1'b0, m_vs[k][VW-1 -: 2]};
        return v;
    endfunction

    function automatic logic [NV-1:0] exp_vs_implied();
        logic [NV-1:0] v;
        for (int k = 0; k < NV; k++) v[k] = m_vs[k][WL];
        return v;
    endfunction

    function automatic logic [WL*NV-1:0] exp_vs_level();
        logic [WL*NV-1:0] v;
        for (int k = 0; k < NV; k++) v[WL*k +: WL] = m_vs[k][WL-1:0];
        return v;
    endfunction

    function automatic logic [WB*NL-1:0] exp_ls_bin();
        logic [WB*NL-1:0] v;
        for (int k = 0; k < NL; k++) v[WB*k +: WB] = m_ls[k] >> 1;
        return v;
    endfunction

    function automatic logic [NL-1:0] exp_ls_bkt();
        logic [NL-1:0] v;
        for (int k = 0; k < NL; k++) v[k] = m_ls[k][0];
        return v;
    endfunction

    function automatic logic [2*NV-1:0] rand_clause();
        logic [2*NV-1:0] c;
        for (int k = 0; k < NV; k++) c[2*k +: 2] = 2'($urandom_range(0, 3));
        return c;
    endfunction

    task automatic randomize_data;
        clause_i = rand_clause();
        for (int k = 0; k < NV; k++) var_states_i[k*VW +: VW] = VW'($urandom);
        for (int k = 0; k < NL; k++) lvl_states_i[k*LW +: LW] = LW'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        randomize_data();
        model_clear();
        #2;
        n_cmp++;
        if ({clause_slot_o, lit_pos_o, lit_neg_o, lit_cnt_o, lit_err_o, clause_upd_o, vs_value_o,
             vs_implied_o, vs_level_o, vs_upd_o, ls_dcd_bin_o, ls_has_bkt_o, ls_upd_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: pos=%h neg=%h cnt=%0d vs_level=%h ls_bin=%h not all zero",
                     lit_pos_o, lit_neg_o, lit_cnt_o, vs_level_o, ls_dcd_bin_o);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_clause_decode;
        wr_carray_i = 8'b00000100;
        clause_i    = 16'b10_00_01_00_00_10_00_01;
        model_capture();
        step();
        idle_inputs();
        clause_i = 16'hFFFF;
        n_cmp++;
        if (lit_pos_o !== 8'b10000100) begin n_bad++; $display("FAIL dec_pos: got %b want 10000100", lit_pos_o); end
        n_cmp++;
        if (lit_neg_o !== 8'b00100001) begin n_bad++; $display("FAIL dec_neg: got %b want 00100001", lit_neg_o); end
        n_cmp++;
        if (lit_cnt_o !== 4'd4 || lit_err_o !== 1'b0) begin
            n_bad++; $display("FAIL dec_cnt_err: got cnt=%0d err=%b want 4/0", lit_cnt_o, lit_err_o);
        end
        n_cmp++;
        if (clause_upd_o !== 1'b1 || clause_slot_o !== 8'b00000100) begin
            n_bad++; $display("FAIL dec_upd_slot: got upd=%b slot=%b want 1/00000100", clause_upd_o, clause_slot_o);
        end
        model_capture();
        step();
        n_cmp++;
        if (clause_upd_o !== 1'b0 || lit_pos_o !== 8'b10000100 || lit_cnt_o !== 4'd4) begin
            n_bad++; $display("FAIL dec_hold: got upd=%b pos=%b cnt=%0d want 0/10000100/4", clause_upd_o, lit_pos_o, lit_cnt_o);
        end
    endtask

    task automatic test_invalid_pair;
        wr_carray_i = 8'b00010000;
        clause_i    = 16'b00_00_00_00_11_00_00_00;
        model_capture();
        step();
        idle_inputs();
        n_cmp++;
        if (lit_err_o !== 1'b1 || lit_cnt_o !== 4'd0 || lit_pos_o !== '0 || lit_neg_o !== '0) begin
            n_bad++;
            $display("FAIL invalid_pair: got err=%b cnt=%0d pos=%b neg=%b want 1/0/0/0",
                     lit_err_o, lit_cnt_o, lit_pos_o, lit_neg_o);
        end
    endtask

    task automatic test_vs_shift;
        for (int k = 0; k < NV; k++) begin
            randomize_data();
            wr_var_states_i = NV'(1) << k;
            var_states_i[k*VW +: VW] = {2'b01, 1'b1, 16'(k + 3)};
            model_capture();
            step();
            n_cmp++;
            if (vs_upd_o !== 1'b1) begin n_bad++; $display("FAIL vs_shift_upd%0d: got %b want 1", k, vs_upd_o); end
        end
        idle_inputs();
        for (int k = 0; k < NV; k++) begin
            n_cmp++;
            if (vs_level_o[WL*k +: WL] !== 16'(k + 3) || vs_value_o[3*k +: 3] !== 3'b001) begin
                n_bad++;
                $display("FAIL vs_shift_slot%0d: got level=%0d value=%b want %0d/001",
                         k, vs_level_o[WL*k +: WL], vs_value_o[3*k +: 3], k + 3);
            end
        end
        n_cmp++;
        if (vs_implied_o !== 8'hFF) begin n_bad++; $display("FAIL vs_shift_implied: got %h want ff", vs_implied_o); end
        model_capture();
        step();
        n_cmp++;
        if (vs_upd_o !== 1'b0) begin n_bad++; $display("FAIL vs_shift_upd_end: got %b want 0", vs_upd_o); end
    endtask

    task automatic test_ls_partial;
        lvl_states_i = '0;
        for (int k = 0; k < NL; k++) lvl_states_i[k*LW +: LW] = LW'($urandom);
        wr_lvl_states_i = 8'b00000100;
        lvl_states_i[2*LW +: LW] = {10'd5, 1'b1};
        model_capture();
        step();
        idle_inputs();
        n_cmp++;
        if (ls_dcd_bin_o !== (80'd5 << (2*WB)) || ls_has_bkt_o !== 8'b00000100 || ls_upd_o !== 1'b1) begin
            n_bad++;
            $display("FAIL ls_partial: got bin=%h bkt=%b upd=%b want bin slot2=5 bkt=00000100 upd=1",
                     ls_dcd_bin_o, ls_has_bkt_o, ls_upd_o);
        end
    endtask

    task automatic test_simultaneous;
        randomize_data();
        wr_carray_i     = 8'b00000001;
        wr_var_states_i = 8'b00000001;
        wr_lvl_states_i = 8'b00000001;
        model_capture();
        step();
        idle_inputs();
        n_cmp++;
        if ({clause_upd_o, vs_upd_o, ls_upd_o} !== 3'b111) begin
            n_bad++; $display("FAIL simul_pulses: got %b want 111", {clause_upd_o, vs_upd_o, ls_upd_o});
        end
        n_cmp++;
        if (lit_pos_o !== exp_mask(m_clause, 2'b10) || vs_level_o !== exp_vs_level() ||
            ls_dcd_bin_o !== exp_ls_bin()) begin
            n_bad++;
            $display("FAIL simul_data: got pos=%b lvl=%h bin=%h want pos=%b lvl=%h bin=%h",
                     lit_pos_o, vs_level_o, ls_dcd_bin_o, exp_mask(m_clause, 2'b10), exp_vs_level(), exp_ls_bin());
        end
    endtask

    task automatic test_random_traffic;
        logic [NV-1:0] ep, en;
        int            ec;
        for (int i = 0; i < 60; i++) begin
            randomize_data();
            case ($urandom_range(0, 3))
                0: wr_carray_i = '0;
                1: wr_carray_i = NC'($urandom);
                default: wr_carray_i = NC'(1) << $urandom_range(0, NC - 1);
            endcase
            wr_var_states_i = ($urandom_range(0, 2) == 0) ? NV'(0) : NV'($urandom);
            wr_lvl_states_i = ($urandom_range(0, 2) == 0) ? NL'(0) : NL'($urandom);
            model_capture();
            step();
            ep = exp_mask(m_clause, 2'b10);
            en = exp_mask(m_clause, 2'b01);
            ec = $countones(ep) + $countones(en);
            n_cmp++;
            if (lit_pos_o !== ep || lit_neg_o !== en || lit_cnt_o !== 4'(ec) ||
                lit_err_o !== (exp_mask(m_clause, 2'b11) != 0) || clause_slot_o !== m_slot) begin
                n_bad++;
                $display("FAIL rnd_clause%0d: got pos=%b neg=%b cnt=%0d err=%b slot=%b want %b/%b/%0d/slot=%b",
                         i, lit_pos_o, lit_neg_o, lit_cnt_o, lit_err_o, clause_slot_o, ep, en, ec, m_slot);
            end
            n_cmp++;
            if (vs_value_o !== exp_vs_value() || vs_implied_o !== exp_vs_implied() || vs_level_o !== exp_vs_level()) begin
                n_bad++;
                $display("FAIL rnd_vs%0d: got val=%h imp=%b lvl=%h want %h/%b/%h",
                         i, vs_value_o, vs_implied_o, vs_level_o, exp_vs_value(), exp_vs_implied(), exp_vs_level());
            end
            n_cmp++;
            if (ls_dcd_bin_o !== exp_ls_bin() || ls_has_bkt_o !== exp_ls_bkt()) begin
                n_bad++;
                $display("FAIL rnd_ls%0d: got bin=%h bkt=%b want %h/%b", i, ls_dcd_bin_o, ls_has_bkt_o, exp_ls_bin(), exp_ls_bkt());
            end
            n_cmp++;
            if ({clause_upd_o, vs_upd_o, ls_upd_o} !== {m_cupd, m_vupd, m_lupd}) begin
                n_bad++;
                $display("FAIL rnd_upd%0d: got %b want %b", i, {clause_upd_o, vs_upd_o, ls_upd_o}, {m_cupd, m_vupd, m_lupd});
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream;
        randomize_data();
        clause_i        = 16'b10_10_10_10_01_01_01_01;
        wr_carray_i     = 8'b10000000;
        wr_var_states_i = 8'hFF;
        wr_lvl_states_i = 8'hFF;
        step();
        idle_inputs();
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if ({clause_slot_o, lit_pos_o, lit_neg_o, lit_cnt_o, lit_err_o, clause_upd_o, vs_value_o,
             vs_implied_o, vs_level_o, vs_upd_o, ls_dcd_bin_o, ls_has_bkt_o, ls_upd_o} !== '0) begin
            n_bad++;
            $display("FAIL midstream_reset: pos=%b neg=%b slot=%b upd=%b%b%b not all zero",
                     lit_pos_o, lit_neg_o, clause_slot_o, clause_upd_o, vs_upd_o, ls_upd_o);
        end
        #2;
        rst = 1'b1;
        step();
        wr_carray_i = 8'b00000010;
        clause_i    = 16'b00_00_00_00_00_00_01_10;
        model_capture();
        step();
        idle_inputs();
        n_cmp++;
        if (lit_pos_o !== 8'b00000001 || lit_neg_o !== 8'b00000010 || lit_cnt_o !== 4'd2 ||
            clause_upd_o !== 1'b1 || vs_level_o !== '0) begin
            n_bad++;
            $display("FAIL resume_after_reset: got pos=%b neg=%b cnt=%0d upd=%b lvl=%h want 00000001/00000010/2/1/0",
                     lit_pos_o, lit_neg_o, lit_cnt_o, clause_upd_o, vs_level_o);
        end
    endtask

    initial begin
        test_reset();
        test_clause_decode();
        test_invalid_pair();
        test_vs_shift();
        test_ls_partial();
        test_simultaneous();
        test_random_traffic();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clause_data.md
Name: clause_data

Overview:
Capture-and-decode block for the bin-load stream into the SAT engine. It snoops the clause, variable-state and level-state write buses and holds the most recent data in registers. It exposes decoded per-literal, per-variable and per-level fields for checkers, debug monitors and status logic. It is passive: it never back-pressures or alters the load stream.

Parameters:
NUM_CLAUSES_A_BIN, 8, clause slots per bin (width of the clause write strobe)
NUM_VARS_A_BIN, 8, variables per bin; a clause is NUM_VARS_A_BIN*2 bits
NUM_LVLS_A_BIN, 8, level-state slots per bin
WIDTH_LVL, 16, decision level width
WIDTH_BIN_ID, 10, bin id width
WIDTH_VAR_STATES, 19, var state word; must equal 3+WIDTH_LVL
WIDTH_LVL_STATES, 11, lvl state word; must equal WIDTH_BIN_ID+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
wr_carray_i  in  NUM_CLAUSES_A_BIN  one-hot clause write strobe; any nonzero value captures
clause_i  in  2*NUM_VARS_A_BIN  clause, 2 bits per variable
wr_var_states_i  in  NUM_VARS_A_BIN  per-slot var-state write strobe
var_states_i  in  WIDTH_VAR_STATES*NUM_VARS_A_BIN  packed var states, slot k at [k*W +: W]
wr_lvl_states_i  in  NUM_LVLS_A_BIN  per-slot lvl-state write strobe
lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS_A_BIN  packed lvl states
clause_slot_o  out  NUM_CLAUSES_A_BIN  strobe value latched with the last clause
lit_pos_o  out  NUM_VARS_A_BIN  bit k: variable k appears positive
lit_neg_o  out  NUM_VARS_A_BIN  bit k: variable k appears negated
lit_cnt_o  out  4  number of literals in the held clause (0..NUM_VARS_A_BIN)
lit_err_o  out  1  held clause has a 2'b11 pair
clause_upd_o  out  1  one-cycle pulse after a clause capture
vs_value_o  out  3*NUM_VARS_A_BIN  per-variable value field
vs_implied_o  out  NUM_VARS_A_BIN  per-variable implied flag
vs_level_o  out  WIDTH_LVL*NUM_VARS_A_BIN  per-variable decision level
vs_upd_o  out  1  pulse after any var-state capture
ls_dcd_bin_o  out  WIDTH_BIN_ID*NUM_LVLS_A_BIN  per-level deciding bin
ls_has_bkt_o  out  NUM_LVLS_A_BIN  per-level has-backtracked flag
ls_upd_o  out  1  pulse after any lvl-state capture

Behaviour:
- Reset (rst low, asynchronous): every register and every output is 0.
- Literal pair k = clause[2k+1:2k]:
  - 2'b10: positive literal.
  - 2'b01: negated literal.
  - 2'b00: absent.
  - 2'b11: invalid. Sets lit_err_o; the pair counts in neither mask nor lit_cnt_o.
- Clause capture:
  - When wr_carray_i != 0 at a clk edge, register clause_i and wr_carray_i.
  - Decoded outputs are valid one cycle after the strobe edge; clause_upd_o pulses that same cycle.
  - Decode is combinational from the held register.
  - Held values persist until the next capture.
  - A strobe with more than one bit set is captured as-is.
- Var-state word, W = 3+WIDTH_LVL:
  - value = [W-1:WIDTH_LVL+1] (2 bits, zero-extended to 3 on output).
  - implied = [WIDTH_LVL].
  - level = [WIDTH_LVL-1:0].
- Var-state capture: slot k updates only when wr_var_states_i[k] is high; other slots hold. This matches the shifting one-hot scatter protocol.
- Lvl-state word: {dcd_bin, has_bkt}, so has_bkt is bit 0. Per-slot capture uses the same rule as var states.
- Update pulses:
  - vs_upd_o and ls_upd_o are registered: high for one cycle after any strobe bit was set.
  - Consecutive strobe cycles give consecutive pulse cycles.
- Simultaneous clause, vs and ls strobes are independent; all captures happen in the same edge.
- Reset mid-stream clears all held data; the next strobe resumes normally.
- Output latency: one clock from strobe edge for all three groups.

Decomposition:
- Shared package clause_data_pkg:
  - LIT_NONE=2'b00, LIT_NEG=2'b01, LIT_POS=2'b10, LIT_BAD=2'b11.
  - Field offset constants for var-state and lvl-state words.
- One natural sub-module, slot_capture_reg: a parameterised per-slot strobe-enabled register array, instantiated once for var states and once for lvl states.
- Literal decode and popcount stay inline.

Test Plan:
- Reset: assert rst=0 mid-operation → all outputs 0 immediately, before any clk edge.
- Clause decode: wr_carray_i=8'b00000100, clause_i=16'b10_00_01_00_00_10_00_01 → next cycle:
  - lit_pos_o=8'b10000100, lit_neg_o=8'b00100001.
  - lit_cnt_o=4, lit_err_o=0, clause_upd_o=1 for one cycle, clause_slot_o=8'b00000100.
- Invalid pair: clause_i with pair 3 = 2'b11, others 00 → lit_err_o=1, lit_cnt_o=0, masks 0.
- Var-state shift: drive wr_var_states_i 1,2,4,…,128 on 8 consecutive cycles; slot k carries {2'b01,1'b1,16'd(k+3)} and all other slots carry garbage → after the last edge:
  - vs_level_o slot k = k+3, vs_implied_o=8'hFF, vs_value_o slot k = 3'b001.
  - vs_upd_o high for 8 consecutive cycles.
- Lvl-state partial write: write only slot 2 with {10'd5,1'b1} → ls_dcd_bin_o slot 2 = 5, ls_has_bkt_o=8'b00000100; other slots remain 0.
- Simultaneous: clause, vs slot 0 and ls slot 0 strobed in the same cycle → all three update pulses fire together next cycle, with correct data in each group.
